result_writeback: RTL and testbench
===================================

RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of PE result lanes per output vector.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the width of each PE result.
REQ-003 The block SHALL have parameter ADDR_W, default 8, giving the width of the output memory address.
REQ-004 The block SHALL have parameter DEPTH, default 4, giving the number of FIFO entries (power of two).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle pulse that arms a new output pass.
REQ-008 The block SHALL have port base_addr, input, ADDR_W bits: first output address, sampled on start.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the PE result vector is valid.
REQ-010 The block SHALL have port in_data, input, N*DATA_W bits: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-011 The block SHALL have port in_last, input, 1 bit: marks the final vector of the pass.
REQ-012 The block SHALL have port in_ready, output, 1 bit: the block accepts the vector this cycle.
REQ-013 The block SHALL have port mem_wr_en, output, 1 bit: output memory write strobe.
REQ-014 The block SHALL have port mem_wr_addr, output, ADDR_W bits: output memory write address.
REQ-015 The block SHALL have port mem_wr_data, output, DATA_W bits: output memory write data.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when the pass completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FIN.
REQ-018 In IDLE, start SHALL load the address counter with base_addr, clear the FIFO and lane counter, and move to RUN.
REQ-019 In RUN, when the FIFO is non-empty, one lane SHALL be written per cycle in order 0..N-1, and the entry SHALL be popped after lane N-1.
REQ-020 in_ready SHALL equal (state==RUN) && !fifo_full; a vector SHALL be pushed on the cycle in_valid && in_ready.
REQ-021 When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle; otherwise simultaneous push and pop SHALL both take effect.
REQ-022 mem_wr_en, mem_wr_addr and mem_wr_data SHALL be registered; a vector pushed at edge t SHALL produce its lane-0 write at edge t+1 at the earliest.
REQ-023 The address SHALL increment by 1 after every write and wrap modulo 2^ADDR_W with no error indication.
REQ-024 After the lane N-1 write of an entry tagged in_last, the FSM SHALL enter FIN; vectors after the last one SHALL NOT be accepted.
REQ-025 In FIN, done SHALL pulse for exactly one cycle and the FSM SHALL return to IDLE.
REQ-026 start SHALL be ignored in RUN and FIN; in_valid SHALL be ignored in IDLE and FIN.

Reset
REQ-027 With rst low at a clock edge, the block SHALL enter IDLE and clear the FIFO pointers, lane counter and address counter.
REQ-028 During reset, in_ready, mem_wr_en and done SHALL be 0, and mem_wr_addr and mem_wr_data SHALL be 0.
REQ-029 A reset in the middle of a pass SHALL abort it: no further writes SHALL occur and no done pulse SHALL be produced.

Configuration
REQ-030 Macro WB_RELU_EN SHALL control clamping: when defined, each lane SHALL be treated as signed and negative values SHALL be written as 0.
REQ-031 When WB_RELU_EN is undefined, lanes SHALL be written unmodified.

Structure
REQ-032 Package wb_pkg SHALL hold the state enum type wb_state_t and the default DATA_W and ADDR_W constants.
REQ-033 The FIFO SHALL be a sub-module, wb_fifo, parameterised by width N*DATA_W and by DEPTH, with full and empty outputs.

Verification
REQ-034 The bench SHALL cover the basic pass: start with base_addr=0x10, then one vector {4,3,2,1} (lane0=1) with in_last -> writes (0x10,1), (0x11,2), (0x12,3), (0x13,4) on consecutive cycles, followed by done one cycle later.
REQ-035 The bench SHALL cover backpressure: 6 back-to-back vectors with DEPTH=4 -> in_ready drops once the FIFO is full, all 24 writes arrive in order, and no vector is lost or duplicated.
REQ-036 The bench SHALL cover address wrap: base_addr=0xFE with 1 vector -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-037 The bench SHALL cover mid-pass reset: rst low after the 2nd write -> mem_wr_en is 0 on the next cycle, the FSM is in IDLE, and done never pulses.
REQ-038 The bench SHALL cover WB_RELU_EN: lane values 0xF0 and 0x05 -> writes 0x00 and 0x05 when the macro is defined, and 0xF0 and 0x05 when it is undefined.
REQ-039 The bench SHALL cover ignored inputs: start asserted during RUN and in_valid asserted in IDLE -> the address is not reloaded and no push occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the result writeback slice.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } wb_state_t;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 8;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Vector FIFO for result writeback; a push is refused whenever the FIFO is full.
// DEPTH must be a power of two, at least 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Pointer update with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {LVL_W{1'b0}};
            rd_ptr_r <= {LVL_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {LVL_W{1'b0}};
            rd_ptr_r <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + LVL_W'(32'd1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + LVL_W'(32'd1);
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Serialises buffered PE result vectors into per-lane output memory writes.
// Optional macro WB_RELU_EN clamps negative (signed) lanes to zero before writing.
module result_writeback
    import wb_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                done
);

    localparam int VEC_W  = N * DATA_W;
    localparam int LANE_W = clog2_min1(N);
    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(32'd1);

    wb_state_t         state_r;
    wb_state_t         state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [LANE_W-1:0] lane_r;
    logic [LANE_W-1:0] lane_nxt_s;
    logic              last_seen_r;
    logic              last_seen_nxt_s;
    logic              mem_wr_en_r;
    logic              wr_en_nxt_s;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [ADDR_W-1:0] wr_addr_nxt_s;
    logic [DATA_W-1:0] mem_wr_data_r;
    logic [DATA_W-1:0] wr_data_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_clr_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [PTR_W:0]    fifo_level_s;
    logic [VEC_W-1:0]  head_s;
    logic [DATA_W-1:0] lane_data_s;

    function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] v);
`ifdef WB_RELU_EN
        relu_f = v[DATA_W-1] ? {DATA_W{1'b0}} : v;
`else
        relu_f = v;
`endif
    endfunction

    wb_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr_s),
        .push  (push_s),
        .wdata (in_data),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Once the last vector is taken the pass is closed to further input.
    assign in_ready_s  = rst && (state_r == RUN) && !fifo_full_s && !last_seen_r;
    assign push_s      = in_valid && in_ready_s;
    assign lane_data_s = head_s[lane_r * DATA_W +: DATA_W];

    assign in_ready    = in_ready_s;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign done        = done_r;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s     = state_r;
        addr_nxt_s      = addr_r;
        lane_nxt_s      = lane_r;
        last_seen_nxt_s = last_seen_r;
        fifo_clr_s      = 1'b0;
        pop_s           = 1'b0;
        wr_en_nxt_s     = 1'b0;
        wr_addr_nxt_s   = mem_wr_addr_r;
        wr_data_nxt_s   = mem_wr_data_r;
        done_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_nxt_s      = base_addr;
                    lane_nxt_s      = {LANE_W{1'b0}};
                    last_seen_nxt_s = 1'b0;
                    fifo_clr_s      = 1'b1;
                    state_nxt_s     = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!fifo_empty_s) begin
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = addr_r;
                    wr_data_nxt_s = relu_f(lane_data_s);
                    addr_nxt_s    = addr_r + ADDR_W'(32'd1);
                    if (lane_r == LANE_LAST) begin
                        lane_nxt_s = {LANE_W{1'b0}};
                        pop_s      = 1'b1;
                        // The tagged vector is always the only one left when it drains.
                        if (last_seen_r && (fifo_level_s == LVL_ONE)) begin
                            state_nxt_s = FIN;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        lane_nxt_s = lane_r + LANE_W'(32'd1);
                    end
                end else begin
                    state_nxt_s = RUN;
                end
                if (push_s && in_last) begin
                    last_seen_nxt_s = 1'b1;
                end else begin
                    last_seen_nxt_s = last_seen_r;
                end
            end
            FIN: begin
                done_nxt_s  = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters and registered write port / done strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r        <= {ADDR_W{1'b0}};
            lane_r        <= {LANE_W{1'b0}};
            last_seen_r   <= 1'b0;
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= {ADDR_W{1'b0}};
            mem_wr_data_r <= {DATA_W{1'b0}};
            done_r        <= 1'b0;
        end else begin
            addr_r        <= addr_nxt_s;
            lane_r        <= lane_nxt_s;
            last_seen_r   <= last_seen_nxt_s;
            mem_wr_en_r   <= wr_en_nxt_s;
            mem_wr_addr_r <= wr_addr_nxt_s;
            mem_wr_data_r <= wr_data_nxt_s;
            done_r        <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback; expectations come from a lane/address model.
module tb_result_writeback;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic                in_valid = 1'b0;
    logic [N*DATA_W-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic                done;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int next_k = 0;
    logic [ADDR_W-1:0]        pass_base = '0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [N*DATA_W-1:0]      vecs [8];

    result_writeback #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] model_lane(input logic [DATA_W-1:0] v);
`ifdef WB_RELU_EN
        return ($signed(v) < 0) ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected writes: lane l of the k-th accepted vector goes to base + 4k + l.
    task automatic expect_vec(input logic [N*DATA_W-1:0] v);
        for (int l = 0; l < N; l++) begin
            exp_q.push_back({pass_base + ADDR_W'(next_k), model_lane(v[l*DATA_W +: DATA_W])});
            next_k++;
        end
    endtask

    task automatic monitor();
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
            end else begin
                if (mem_wr_en) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(mem_wr_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                        chk("wr_data", 32'(mem_wr_data), 32'(e[DATA_W-1:0]));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_with_pending", exp_q.size(), 0);
                end
            end
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        pass_base = base;
        next_k = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input logic [ADDR_W-1:0] base, input int nvec, input bit gaps,
                            input bit glitch, input bit hold, output bit stalled);
        int d0;
        bit acc;
        stalled = 1'b0;
        d0 = done_cnt;
        do_start(base);
        for (int i = 0; i < nvec; i++) begin
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                in_valid = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                in_data  = vecs[i];
                in_last  = (i == nvec - 1);
                if (glitch && i == 1) begin
                    start = 1'b1;
                    base_addr = base + 8'h40;
                end
                @(negedge clk);
                if (in_valid && in_ready) begin
                    acc = 1'b1;
                    expect_vec(vecs[i]);
                end else if (in_valid) begin
                    stalled = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        in_valid = hold;
        in_last  = 1'b0;
        in_data  = $urandom;
        for (int c = 0; c < 300 && done_cnt == d0; c++) begin
            @(negedge clk); #1;
            if (hold) chk("ready_after_last", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk("done_count", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit st;
        int w0;
        int d0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_addr", 32'(mem_wr_addr), 0);
        chk("rst_wr_data", 32'(mem_wr_data), 0);
        rst = 1'b1;

        // in_valid while idle is ignored
        w0 = wr_cnt;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = $urandom;
            @(negedge clk);
            chk("idle_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_no_write", wr_cnt - w0, 0);

        // Basic pass with exact timing
        d0 = done_cnt;
        do_start(8'h10);
        in_valid = 1'b1;
        in_data  = 32'h04030201;
        in_last  = 1'b1;
        @(negedge clk);
        chk("basic_ready", 32'(in_ready), 1);
        expect_vec(in_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("basic_latency", 32'(mem_wr_en), 0);
        for (int l = 0; l < N; l++) begin
            @(negedge clk);
            chk("basic_wr_en", 32'(mem_wr_en), 1);
        end
        @(negedge clk);
        chk("basic_done", 32'(done), 1);
        @(negedge clk);
        chk("basic_done_once", 32'(done), 0);
        chk("basic_done_count", done_cnt - d0, 1);

        // Clamp behaviour on negative lanes
        vecs[0] = 32'h7F8005F0;
        run_pass(8'h30, 1, 1'b0, 1'b0, 1'b0, st);

        // Address wrap
        vecs[0] = $urandom;
        run_pass(8'hFE, 1, 1'b0, 1'b0, 1'b0, st);

        // Backpressure with six back-to-back vectors
        w0 = wr_cnt;
        for (int i = 0; i < 6; i++) vecs[i] = $urandom;
        run_pass(8'h50, 6, 1'b0, 1'b0, 1'b1, st);
        chk("bp_stalled", 32'(st), 1);
        chk("bp_write_count", wr_cnt - w0, 24);

        // start during RUN is ignored
        for (int i = 0; i < 3; i++) vecs[i] = $urandom;
        run_pass(8'h60, 3, 1'b0, 1'b1, 1'b0, st);

        // Mid-pass reset
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(8'h20);
        in_valid = 1'b1;
        in_data  = $urandom;
        in_last  = 1'b1;
        @(negedge clk);
        if (in_ready) expect_vec(in_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < 50 && (wr_cnt - w0) < 2; c++) begin
            @(negedge clk); #1;
        end
        chk("mid_two_writes", wr_cnt - w0, 2);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_wr_en_off", 32'(mem_wr_en), 0);
        chk("mid_ready_off", 32'(in_ready), 0);
        chk("mid_addr_zero", 32'(mem_wr_addr), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_idle_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_no_more_writes", wr_cnt - w0, 2);
        chk("mid_no_done", done_cnt - d0, 0);

        // Randomised passes
        for (int p = 0; p < 5; p++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) vecs[i] = $urandom;
            run_pass(ADDR_W'($urandom), n, 1'b1, 1'b0, 1'($urandom_range(0, 1)), st);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
